datapath: RTL and testbench

//  32-bit single-bus CPU datapath: 16 GPRs, PC, MDR, MAR, HI, LO, Y, 64-bit Z, ALU.
//  A control unit drives one-hot register-in and source-select strobes each step.
//  All transfers go over one shared 32-bit bus.

---
 rtl/datapath_pkg.sv | 23 ++
 rtl/datapath_alu.sv | 61 ++++++
 rtl/datapath.sv | 104 ++++++++++
 tb/tb_datapath.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared definitions for the single-bus datapath: word width, register count, ALU opcodes.
package datapath_pkg;

  localparam int WORD_W  = 32;
  localparam int NUM_GPR = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A comes from Y, B from the bus; 64-bit result feeds Z.
// Multiply/divide hardware exists only when DATAPATH_MULDIV_EN is defined.
module datapath_alu
  import datapath_pkg::*;
(
  input  word_t       a,
  input  word_t       b,
  input  logic [4:0]  opcode,
  input  logic        inc_pc,
  output logic [63:0] result
);

  logic [4:0]  amt;
  logic [63:0] ror_w;
  logic [63:0] rol_w;

  // Rotates shift a doubled copy of A, so amount 0 naturally returns A.
  assign amt   = b[4:0];
  assign ror_w = {a, a} >> amt;
  assign rol_w = {a, a} << amt;

`ifdef DATAPATH_MULDIV_EN
  logic signed [63:0] prod;
  logic signed [31:0] quot;
  logic signed [31:0] rem;

  assign prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign quot = $signed(a) / $signed(b);
  assign rem  = $signed(a) % $signed(b);
`endif

  // NOTE: combinational blocks use blocking assignments and assign every output a default first, so no latch is inferred.
  always_comb begin
    result = '0;
    if (inc_pc) begin
      result[31:0] = b + 32'd1;
    end else begin
      case (opcode)
        OP_ADD:  result[31:0] = a + b;
        OP_SUB:  result[31:0] = a - b;
        OP_AND:  result[31:0] = a & b;
        OP_OR:   result[31:0] = a | b;
        OP_SHR:  result[31:0] = a >> amt;
        OP_SHRA: result[31:0] = $signed(a) >>> amt;
        OP_SHL:  result[31:0] = a << amt;
        OP_ROR:  result[31:0] = ror_w[31:0];
        OP_ROL:  result[31:0] = rol_w[63:32];
`ifdef DATAPATH_MULDIV_EN
        OP_MUL:  result = prod;
        OP_DIV:  result = (b == '0) ? {a, 32'h0} : {rem, quot};
`else
        OP_MUL, OP_DIV: result = '0;
`endif
        OP_NEG:  result[31:0] = -b;
        OP_NOT:  result[31:0] = ~b;
        default: result = '0;
      endcase
    end
  end

endmodule

// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: 16 GPRs, PC, MDR, MAR, HI, LO, Y, 64-bit Z and ALU.
// Optional feature macro: DATAPATH_MULDIV_EN (enables mul/div in the ALU).
module datapath
  import datapath_pkg::*;
(
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] Mdatain,
  input  logic        Read,
  input  logic        IncPC,
  input  logic [15:0] Rin,
  input  logic [15:0] Rout,
  input  logic        PCin,
  input  logic        Zin,
  input  logic        MDRin,
  input  logic        MARin,
  input  logic        Yin,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        PCout,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        MDRout,
  input  logic        InPortout,
  input  logic [4:0]  opcode
);

  word_t       r_q [NUM_GPR];
  word_t       r_d [NUM_GPR];
  word_t       pc_q, pc_d;
  word_t       mdr_q, mdr_d;
  word_t       mar_q, mar_d;
  word_t       hi_q, hi_d;
  word_t       lo_q, lo_d;
  word_t       y_q, y_d;
  logic [63:0] z_q, z_d;

  word_t       bus;
  logic [63:0] alu_result;

  // Lowest-priority source is assigned first so the highest-priority one wins.
  always_comb begin
    bus = '0;
    if (InPortout) bus = '0;
    if (MDRout)    bus = mdr_q;
    if (PCout)     bus = pc_q;
    if (Zlowout)   bus = z_q[31:0];
    if (Zhighout)  bus = z_q[63:32];
    if (LOout)     bus = lo_q;
    if (HIout)     bus = hi_q;
    for (int i = NUM_GPR - 1; i >= 0; i--) begin
      if (Rout[i]) bus = r_q[i];
    end
  end

  datapath_alu u_alu (
    .a      (y_q),
    .b      (bus),
    .opcode (opcode),
    .inc_pc (IncPC),
    .result (alu_result)
  );

  always_comb begin
    r_d   = r_q;
    pc_d  = PCin  ? bus : pc_q;
    mar_d = MARin ? bus : mar_q;
    hi_d  = HIin  ? bus : hi_q;
    lo_d  = LOin  ? bus : lo_q;
    y_d   = Yin   ? bus : y_q;
    mdr_d = MDRin ? (Read ? Mdatain : bus) : mdr_q;
    z_d   = Zin   ? alu_result : z_q;
    for (int i = 0; i < NUM_GPR; i++) begin
      if (Rin[i]) r_d[i] = bus;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the GPR array is reset
  // like any other register because every register must read 0 right after clear.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NUM_GPR; i++) r_q[i] <= '0;
      pc_q  <= '0;
      mdr_q <= '0;
      mar_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      y_q   <= '0;
      z_q   <= '0;
    end else begin
      r_q   <= r_d;
      pc_q  <= pc_d;
      mdr_q <= mdr_d;
      mar_q <= mar_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      y_q   <= y_d;
      z_q   <= z_d;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: hand-written transfer sequences plus a table of ALU vectors.
module tb_datapath;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] Mdatain;
  logic        Read, IncPC;
  logic [15:0] Rin, Rout;
  logic        PCin, Zin, MDRin, MARin, Yin, HIin, LOin;
  logic        PCout, Zhighout, Zlowout, HIout, LOout, MDRout, InPortout;
  logic [4:0]  opcode;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  datapath dut (
    .clock(clock), .clear(clear), .Mdatain(Mdatain), .Read(Read), .IncPC(IncPC),
    .Rin(Rin), .Rout(Rout), .PCin(PCin), .Zin(Zin), .MDRin(MDRin), .MARin(MARin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .PCout(PCout), .Zhighout(Zhighout),
    .Zlowout(Zlowout), .HIout(HIout), .LOout(LOout), .MDRout(MDRout),
    .InPortout(InPortout), .opcode(opcode)
  );

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic        inc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    Read = 0; IncPC = 0; Rin = '0; Rout = '0;
    PCin = 0; Zin = 0; MDRin = 0; MARin = 0; Yin = 0; HIin = 0; LOin = 0;
    PCout = 0; Zhighout = 0; Zlowout = 0; HIout = 0; LOout = 0; MDRout = 0;
    InPortout = 0; opcode = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic put_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1; MDRin = 1;
    tick();
  endtask

  task automatic settle();
    #1;
  endtask

  // Reads GPR n onto the bus and compares it.
  task automatic check_gpr(input string name, input int n, input logic [31:0] exp);
    Rout[n] = 1'b1; settle();
    check(name, dut.bus, exp);
    idle();
  endtask

  task automatic run_alu(input vec_t v);
    put_mdr(v.a);
    MDRout = 1; Yin = 1;
    tick();
    put_mdr(v.b);
    MDRout = 1; opcode = v.op; IncPC = v.inc; Zin = 1;
    tick();
    Zlowout = 1; settle();
    check({v.name, "_lo"}, dut.bus, v.lo);
    idle();
    Zhighout = 1; settle();
    check({v.name, "_hi"}, dut.bus, v.hi);
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    idle();
    Mdatain = '0;
    clear = 1;
    #12;
    clear = 0;
    @(negedge clock);

    // MDR load from memory, then to R4.
    put_mdr(32'h12);
    MDRout = 1; Rin[4] = 1;
    tick();
    check_gpr("mdr_to_r4", 4, 32'h12);

    // R0 = R4 - R5.
    put_mdr(32'h14);
    MDRout = 1; Rin[5] = 1;
    tick();
    Rout[4] = 1; Yin = 1;
    tick();
    Rout[5] = 1; opcode = 5'b00100; Zin = 1;
    tick();
    Zlowout = 1; Rin[0] = 1;
    tick();
    check_gpr("sub_r0", 0, 32'hFFFF_FFFE);
    Zhighout = 1; settle();
    check("sub_zhigh", dut.bus, 32'h0);
    idle();

    // PC increment: MAR gets old PC, Z gets PC+1, PC itself untouched.
    PCout = 1; MARin = 1; IncPC = 1; Zin = 1;
    tick();
    check("incpc_mar", dut.mar_q, 32'h0);
    Zlowout = 1; settle();
    check("incpc_zlow", dut.bus, 32'h1);
    idle();
    PCout = 1; settle();
    check("incpc_pc_unchanged", dut.bus, 32'h0);
    idle();
    Zlowout = 1; PCin = 1;
    tick();
    PCout = 1; settle();
    check("pc_load", dut.bus, 32'h1);
    idle();

    // Z is both source and destination: captures old Zlow + 1 exactly once.
    Zlowout = 1; IncPC = 1; Zin = 1;
    tick();
    Zlowout = 1; settle();
    check("same_edge_z", dut.bus, 32'h2);
    idle();

    // R5 reads old R4 while R4 rewrites itself.
    Rout[4] = 1; Rin[4] = 1; Rin[5] = 1;
    tick();
    check_gpr("same_edge_r4", 4, 32'h12);
    check_gpr("same_edge_r5", 5, 32'h12);

    // HI = R0, LO stays 0; bus priority checks.
    Rout[0] = 1; HIin = 1;
    tick();
    Rout[0] = 1; Rout[4] = 1; settle();
    check("prio_r0_over_r4", dut.bus, 32'hFFFF_FFFE);
    idle();
    Rout[4] = 1; HIout = 1; settle();
    check("prio_r4_over_hi", dut.bus, 32'h12);
    idle();
    HIout = 1; LOout = 1; settle();
    check("prio_hi_over_lo", dut.bus, 32'hFFFF_FFFE);
    idle();
    LOout = 1; Zlowout = 1; settle();
    check("prio_lo_over_zlow", dut.bus, 32'h0);
    idle();
    PCout = 1; MDRout = 1; settle();
    check("prio_pc_over_mdr", dut.bus, 32'h1);
    idle();

    // MDR loads from the bus when Read=0.
    Rout[4] = 1; MDRin = 1; Read = 0; Mdatain = 32'hDEAD_BEEF;
    tick();
    MDRout = 1; settle();
    check("mdr_from_bus", dut.bus, 32'h12);
    idle();

    vecs.push_back('{"add",      32'd5,          32'd7,          5'b00011, 1'b0, 32'h0, 32'd12});
    vecs.push_back('{"add_wrap", 32'hFFFF_FFFF,  32'h1,          5'b00011, 1'b0, 32'h0, 32'h0});
    vecs.push_back('{"sub",      32'h12,         32'h14,         5'b00100, 1'b0, 32'h0, 32'hFFFF_FFFE});
    vecs.push_back('{"and",      32'hF0F0_F0F0,  32'h0FF0_0FF0,  5'b00101, 1'b0, 32'h0, 32'h00F0_00F0});
    vecs.push_back('{"or",       32'hF0F0_F0F0,  32'h0FF0_0FF0,  5'b00110, 1'b0, 32'h0, 32'hFFF0_FFF0});
    vecs.push_back('{"shr",      32'h8000_0000,  32'd4,          5'b00111, 1'b0, 32'h0, 32'h0800_0000});
    vecs.push_back('{"shra",     32'h8000_0000,  32'd4,          5'b01000, 1'b0, 32'h0, 32'hF800_0000});
    vecs.push_back('{"shl31",    32'h1,          32'd31,         5'b01001, 1'b0, 32'h0, 32'h8000_0000});
    vecs.push_back('{"shl_amt5", 32'h1,          32'h23,         5'b01001, 1'b0, 32'h0, 32'h8});
    vecs.push_back('{"ror1",     32'h1,          32'd1,          5'b01010, 1'b0, 32'h0, 32'h8000_0000});
    vecs.push_back('{"ror0",     32'h1234_5678,  32'd0,          5'b01010, 1'b0, 32'h0, 32'h1234_5678});
    vecs.push_back('{"rol4",     32'h8000_0001,  32'd4,          5'b01011, 1'b0, 32'h0, 32'h18});
    vecs.push_back('{"neg",      32'h55,         32'h1,          5'b10001, 1'b0, 32'h0, 32'hFFFF_FFFF});
    vecs.push_back('{"not",      32'h55,         32'h0F0F_0F0F,  5'b10010, 1'b0, 32'h0, 32'hF0F0_F0F0});
    vecs.push_back('{"bad_op",   32'h55,         32'h66,         5'b11111, 1'b0, 32'h0, 32'h0});
    vecs.push_back('{"incpc",    32'h99,         32'h41,         5'b00011, 1'b1, 32'h0, 32'h42});
`ifdef DATAPATH_MULDIV_EN
    vecs.push_back('{"mul_neg",  32'hFFFF_FFFD,  32'd7,          5'b01111, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
    vecs.push_back('{"mul_big",  32'h0001_0000,  32'h0001_0000,  5'b01111, 1'b0, 32'h1, 32'h0});
    vecs.push_back('{"div",      32'd17,         32'd5,          5'b10000, 1'b0, 32'd2, 32'd3});
    vecs.push_back('{"div0",     32'd17,         32'd0,          5'b10000, 1'b0, 32'd17, 32'd0});
    vecs.push_back('{"div_neg",  32'hFFFF_FFEF,  32'd5,          5'b10000, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFD});
`else
    vecs.push_back('{"mul_off",  32'hFFFF_FFFD,  32'd7,          5'b01111, 1'b0, 32'h0, 32'h0});
    vecs.push_back('{"div_off",  32'd17,         32'd5,          5'b10000, 1'b0, 32'h0, 32'h0});
`endif

    foreach (vecs[i]) run_alu(vecs[i]);

    // Mid-run clear between edges: registers go to 0 without waiting for a clock.
    put_mdr(32'hA5A5_A5A5);
    MDRout = 1; Rin[15] = 1; HIin = 1; LOin = 1; PCin = 1; IncPC = 1; Zin = 1;
    tick();
    check_gpr("pre_clear_r15", 15, 32'hA5A5_A5A5);
    Rout[15] = 1;
    #2;
    clear = 1;
    #1;
    check("async_clear_r15", dut.bus, 32'h0);
    #1;
    clear = 0;
    idle();
    for (int n = 0; n < 16; n++) check_gpr($sformatf("clear_r%0d", n), n, 32'h0);
    PCout = 1;    settle(); check("clear_pc", dut.bus, 32'h0);    idle();
    MDRout = 1;   settle(); check("clear_mdr", dut.bus, 32'h0);   idle();
    HIout = 1;    settle(); check("clear_hi", dut.bus, 32'h0);    idle();
    LOout = 1;    settle(); check("clear_lo", dut.bus, 32'h0);    idle();
    Zlowout = 1;  settle(); check("clear_zlow", dut.bus, 32'h0);  idle();
    Zhighout = 1; settle(); check("clear_zhigh", dut.bus, 32'h0); idle();
    check("clear_mar", dut.mar_q, 32'h0);
    settle();
    check("bus_no_select", dut.bus, 32'h0);
    // Y was cleared too: Y + 9 must give 9.
    put_mdr(32'd9);
    MDRout = 1; opcode = 5'b00011; Zin = 1;
    tick();
    Zlowout = 1; settle();
    check("clear_y", dut.bus, 32'd9);
    idle();
    InPortout = 1; settle();
    check("inport_zero", dut.bus, 32'h0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
